// File: rtl/serial_negate_sched.sv
// Shares one bit-serial two's-complement unit between two parallel requesters:
// round-robin grant, LSB-first serialization, reassembly, valid/ready return.
module serial_negate_sched #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             t_clk,
  input  logic             r,
  input  logic             req0,
  input  logic [WIDTH-1:0] din0,
  input  logic             req1,
  input  logic [WIDTH-1:0] din1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             ser_i,
  output logic             ser_start,
  input  logic             ser_y,
  output logic [WIDTH-1:0] dout,
  output logic             dout_id,
  output logic             dout_valid,
  input  logic             dout_ready
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] rsreg_q, rsreg_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             id_q, id_d;
  logic             last_q, last_d;
  logic             dout_id_q, dout_id_d;
  logic             bubble_q, bubble_d;
  logic [WIDTH-1:0] rs_next;

  // Next-state, arbitration and datapath updates
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    rsreg_d   = rsreg_q;
    dout_d    = dout_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    last_d    = last_q;
    dout_id_d = dout_id_q;
    bubble_d  = bubble_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    rs_next   = {ser_y, rsreg_q[WIDTH-1:1]};

    case (state_q)
      IDLE: begin
        bubble_d = 1'b0;
        // The first IDLE cycle after a handoff is a bubble with no grant
        if (!r && !bubble_q) begin
          if (req0 && (!req1 || last_q)) gnt0 = 1'b1;
          else if (req1)                 gnt1 = 1'b1;
        end
        if (gnt0 || gnt1) begin
          sreg_d  = gnt1 ? din1 : din0;
          id_d    = gnt1;
          last_d  = gnt1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sreg_d  = sreg_q >> 1;
        rsreg_d = rs_next;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          dout_d    = rs_next;
          dout_id_d = id_q;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (dout_ready) begin
          state_d  = IDLE;
          bubble_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      rsreg_q   <= '0;
      dout_q    <= '0;
      cnt_q     <= '0;
      id_q      <= 1'b0;
      last_q    <= 1'b1;
      dout_id_q <= 1'b0;
      bubble_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      rsreg_q   <= rsreg_d;
      dout_q    <= dout_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      last_q    <= last_d;
      dout_id_q <= dout_id_d;
      bubble_q  <= bubble_d;
    end
  end

  assign ser_i      = (state_q == SHIFT) & sreg_q[0];
  assign ser_start  = (state_q == SHIFT) & (cnt_q == '0);
  assign dout_valid = (state_q == HOLD);
  assign dout       = dout_q;
  assign dout_id    = dout_id_q;

endmodule

// File: tb/tb_serial_negate_sched.sv
// Bench for serial_negate_sched: serial complementer model, scoreboard of
// expected negations, vector table plus directed timing/corner sequences.
module tb_serial_negate_sched;

  localparam int unsigned W = 8;

  logic         t_clk = 1'b0;
  logic         r;
  logic         req0, req1;
  logic [W-1:0] din0, din1;
  logic         gnt0, gnt1;
  logic         ser_i, ser_start, ser_y;
  logic [W-1:0] dout;
  logic         dout_id, dout_valid, dout_ready;

  serial_negate_sched #(.WIDTH(W)) dut (
    .t_clk(t_clk), .r(r),
    .req0(req0), .din0(din0), .req1(req1), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1),
    .ser_i(ser_i), .ser_start(ser_start), .ser_y(ser_y),
    .dout(dout), .dout_id(dout_id), .dout_valid(dout_valid),
    .dout_ready(dout_ready)
  );

  always #5 t_clk = ~t_clk;

  // Serial two's complement: pass bits through the first 1, invert after it
  logic seen_q;
  logic seen_eff;
  assign seen_eff = ser_start ? 1'b0 : seen_q;
  assign ser_y    = seen_eff ? ~ser_i : ser_i;
  always @(posedge t_clk or posedge r) begin
    if (r) seen_q <= 1'b0;
    else   seen_q <= seen_eff | ser_i;
  end

  int tests = 0;
  int fails = 0;
  int pops  = 0;

  typedef struct packed {
    logic         id;
    logic [W-1:0] data;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_to(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Scoreboard: push on grant, pop on handshake, sampled mid-cycle
  always @(negedge t_clk) begin
    exp_t e;
    if (r) begin
      sb.delete();
    end else begin
      chk("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
      if (gnt0) sb.push_back({1'b0, W'(~din0 + W'(1))});
      if (gnt1) sb.push_back({1'b1, W'(~din1 + W'(1))});
      if (dout_valid && dout_ready) begin
        if (sb.size() == 0) begin
          fail_to("sb_underflow");
        end else begin
          e = sb.pop_front();
          chk("sb_dout", 32'(dout), 32'(e.data));
          chk("sb_dout_id", 32'(dout_id), 32'(e.id));
          pops++;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge t_clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      cyc();
      n++;
    end
    if (sb.size() != 0) fail_to("drain");
    cyc();
    cyc();
  endtask

  task automatic wait_gnt(input logic sel);
    int n = 0;
    while (!(sel ? gnt1 : gnt0) && n < 50) begin
      cyc();
      #1;
      n++;
    end
    if (!(sel ? gnt1 : gnt0)) fail_to("grant_wait");
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!dout_valid && n < 50) begin
      cyc();
      #1;
      n++;
    end
    if (!dout_valid) fail_to("valid_wait");
  endtask

  task automatic run_job(input logic sel, input logic [W-1:0] d,
                         output logic [W-1:0] got, output logic gid);
    cyc();
    if (sel) begin req1 = 1'b1; din1 = d; end
    else     begin req0 = 1'b1; din0 = d; end
    #1;
    wait_gnt(sel);
    cyc();
    req0 = 1'b0;
    req1 = 1'b0;
    #1;
    wait_valid();
    got = dout;
    gid = dout_id;
    cyc();
  endtask

  typedef struct {
    logic         sel;
    logic [W-1:0] din;
    logic [W-1:0] exp;
  } vec_t;
  vec_t tbl[6];

  initial begin
    logic [W-1:0] d;
    logic [W-1:0] got;
    logic         gid;
    logic         g0, g1;
    int n, ng, last_g, start;

    tbl[0] = '{1'b1, 8'h00, 8'h00};
    tbl[1] = '{1'b1, 8'h80, 8'h80};
    tbl[2] = '{1'b1, 8'h01, 8'hFF};
    tbl[3] = '{1'b1, 8'hFF, 8'h01};
    tbl[4] = '{1'b1, 8'h7F, 8'h81};
    tbl[5] = '{1'b1, 8'h06, 8'hFA};

    r = 1'b0; req0 = 1'b0; req1 = 1'b0; din0 = '0; din1 = '0; dout_ready = 1'b1;
    #1 r = 1'b1;
    #1;
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_ser", 32'({ser_i, ser_start, dout_id}), 32'd0);
    repeat (2) cyc();
    r = 1'b0;

    // First job: exact cycle timing of grant, serial bits and result
    cyc();
    d = 8'h06;
    req0 = 1'b1; din0 = d;
    #1;
    chk("t1_gnt0", 32'({gnt0, gnt1}), 32'b10);
    for (int k = 0; k < int'(W); k++) begin
      cyc();
      if (k == 0) req0 = 1'b0;
      #1;
      chk("t1_ser_i", 32'(ser_i), 32'(d[k]));
      chk("t1_ser_start", 32'(ser_start), 32'(k == 0));
      chk("t1_no_valid", 32'(dout_valid), 32'd0);
    end
    cyc();
    #1;
    chk("t1_valid", 32'(dout_valid), 32'd1);
    chk("t1_dout", 32'(dout), 32'h0FA);
    chk("t1_id", 32'(dout_id), 32'd0);
    cyc();
    #1;
    chk("t1_bubble", 32'(dout_valid), 32'd0);
    drain();

    for (int i = 0; i < 6; i++) begin
      run_job(tbl[i].sel, tbl[i].din, got, gid);
      chk("vec_dout", 32'(got), 32'(tbl[i].exp));
      chk("vec_id", 32'(gid), 32'(tbl[i].sel));
    end
    drain();

    // Both requesters held: alternating grants, WIDTH+3 cycles apart
    cyc();
    req0 = 1'b1; req1 = 1'b1; din0 = 8'h11; din1 = 8'h22;
    n = 0; ng = 0; last_g = 0;
    while (ng < 4 && n < 200) begin
      #1;
      if (gnt0 || gnt1) begin
        chk("rr_order", 32'(gnt1), 32'(ng % 2));
        if (ng > 0) chk("rr_gap", 32'(n - last_g), 32'(W + 3));
        last_g = n;
        ng++;
      end
      if (ng < 4) begin
        cyc();
        n++;
      end
    end
    if (ng < 4) fail_to("rr_grants");
    cyc();
    req0 = 1'b0; req1 = 1'b0;
    drain();

    // Backpressure: result held, no grant while HOLD
    dout_ready = 1'b0;
    cyc();
    req0 = 1'b1; din0 = 8'h33;
    #1;
    wait_gnt(1'b0);
    cyc();
    req0 = 1'b0; req1 = 1'b1; din1 = 8'h44;
    #1;
    chk("bp_no_gnt_shift", 32'(gnt1), 32'd0);
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin cyc(); #1; end
      chk("bp_valid", 32'(dout_valid), 32'd1);
      chk("bp_dout", 32'(dout), 32'h0CD);
      chk("bp_id", 32'(dout_id), 32'd0);
      chk("bp_no_gnt", 32'(gnt1), 32'd0);
    end
    cyc();
    dout_ready = 1'b1;
    #1;
    chk("bp_release_no_gnt", 32'(gnt1), 32'd0);
    cyc();
    #1;
    chk("bp_idle_valid", 32'(dout_valid), 32'd0);
    chk("bp_idle_no_gnt", 32'(gnt1), 32'd0);
    cyc();
    #1;
    chk("bp_gnt1", 32'(gnt1), 32'd1);
    cyc();
    req1 = 1'b0;
    drain();

    // Reset at cnt=3 of a job from requester 0
    cyc();
    req0 = 1'b1; din0 = 8'h5A;
    #1;
    wait_gnt(1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k == 0) req0 = 1'b0;
    end
    #1;
    chk("rs_ser_i_pre", 32'(ser_i), 32'd1);
    req0 = 1'b1; req1 = 1'b1;
    #1 r = 1'b1;
    #1;
    chk("rs_ser", 32'({ser_i, ser_start}), 32'd0);
    chk("rs_gnt", 32'({gnt0, gnt1}), 32'd0);
    chk("rs_dout", 32'(dout), 32'd0);
    chk("rs_id_valid", 32'({dout_id, dout_valid}), 32'd0);
    cyc();
    #1 r = 1'b0;
    #1;
    chk("rs_first_gnt", 32'({gnt0, gnt1}), 32'b10);
    cyc();
    req0 = 1'b0; req1 = 1'b0;
    drain();

    // Random traffic checked by the scoreboard
    start = pops; n = 0; g0 = 1'b0; g1 = 1'b0;
    while ((pops - start) < 200 && n < 10000) begin
      cyc();
      if (g0) req0 = 1'b0;
      else if (!req0 && $urandom_range(0, 1) == 1) begin req0 = 1'b1; din0 = W'($urandom); end
      if (g1) req1 = 1'b0;
      else if (!req1 && $urandom_range(0, 1) == 1) begin req1 = 1'b1; din1 = W'($urandom); end
      dout_ready = ($urandom_range(0, 3) != 0);
      #1;
      g0 = gnt0;
      g1 = gnt1;
      n++;
    end
    if ((pops - start) < 200) fail_to("random_jobs");
    cyc();
    req0 = 1'b0; req1 = 1'b0; dout_ready = 1'b1;
    drain();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
